// File: rtl/data_buffer.sv
// 64-byte circular byte FIFO between the AHB slave controller (1/2/4-byte access)
// and the USB packet stages (one byte per cycle in each direction).
module data_buffer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned PTR_W = 7
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        storeTxData,
  input  logic        getRxData,
  input  logic [1:0]  dataSize,
  input  logic [31:0] txWData,
  output logic [31:0] rxRData,
  input  logic        storeRxPacketData,
  input  logic [7:0]  rxPacketData,
  input  logic        getTxPacketData,
  output logic [7:0]  txPacketData,
  input  logic        flush,
  output logic [6:0]  bufferOccupancy,
  output logic        accessError
);

  localparam int unsigned IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] occ_q, occ_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [7:0]       mem_q [DEPTH];

  logic [PTR_W-1:0] occ;
  logic [PTR_W-1:0] n_ptr;
  logic [2:0]       n;
  logic             size_bad;
  logic             ahb_wr_ok;
  logic             usb_wr_ok;
  logic [31:0]      pop_data;

  // Byte count of the AHB transfer; zero marks the illegal encoding.
  always_comb begin
    n = 3'd0;
    case (dataSize)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      2'b10:   n = 3'd4;
      default: n = 3'd0;
    endcase
  end

  assign size_bad = (dataSize == 2'b11);
  assign n_ptr    = PTR_W'(n);
  assign occ      = wr_q - rd_q;

  // Head bytes for an AHB read, little-endian, zero above N (wraps through the index).
  always_comb begin
    pop_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < n) begin
        pop_data[8*k +: 8] = mem_q[IDX_W'(rd_q + PTR_W'(k))];
      end
    end
  end

  // Next-state: flush wins, then write side and read side, each judged on start-of-cycle occupancy.
  always_comb begin
    wr_d      = wr_q;
    rd_d      = rd_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    ahb_wr_ok = 1'b0;
    usb_wr_ok = 1'b0;

    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (storeTxData) begin
        if (!size_bad && ((PTR_W'(DEPTH) - occ) >= n_ptr)) begin
          ahb_wr_ok = 1'b1;
          wr_d      = wr_q + n_ptr;
        end else begin
          err_d = 1'b1;
        end
        if (storeRxPacketData) begin
          err_d = 1'b1;
        end
      end else if (storeRxPacketData) begin
        if (occ != PTR_W'(DEPTH)) begin
          usb_wr_ok = 1'b1;
          wr_d      = wr_q + PTR_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end

      if (getRxData) begin
        if (!size_bad && (occ >= n_ptr)) begin
          rd_d    = rd_q + n_ptr;
          rdata_d = pop_data;
        end else begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
        if (getTxPacketData) begin
          err_d = 1'b1;
        end
      end else if (getTxPacketData) begin
        if (occ != '0) begin
          rd_d = rd_q + PTR_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
    end

    occ_d = wr_d - rd_d;
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array is deliberately left unreset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (ahb_wr_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < n) begin
          mem_q[IDX_W'(wr_q + PTR_W'(k))] <= txWData[8*k +: 8];
        end
      end
    end else if (usb_wr_ok) begin
      mem_q[IDX_W'(wr_q)] <= rxPacketData;
    end
  end

  assign txPacketData    = (occ == '0) ? 8'h00 : mem_q[IDX_W'(rd_q)];
  assign rxRData         = rdata_q;
  assign bufferOccupancy = 7'(occ_q);
  assign accessError     = err_q;

endmodule

// File: tb/tb_data_buffer.sv
// Self-checking bench for data_buffer: directed scenarios plus randomized traffic
// compared against a byte-queue reference model.
module tb_data_buffer;

  logic        clk = 1'b0;
  logic        nRst;
  logic        storeTxData;
  logic        getRxData;
  logic [1:0]  dataSize;
  logic [31:0] txWData;
  logic [31:0] rxRData;
  logic        storeRxPacketData;
  logic [7:0]  rxPacketData;
  logic        getTxPacketData;
  logic [7:0]  txPacketData;
  logic        flush;
  logic [6:0]  bufferOccupancy;
  logic        accessError;

  always #5 clk = ~clk;

  data_buffer dut (
    .clk               (clk),
    .nRst              (nRst),
    .storeTxData       (storeTxData),
    .getRxData         (getRxData),
    .dataSize          (dataSize),
    .txWData           (txWData),
    .rxRData           (rxRData),
    .storeRxPacketData (storeRxPacketData),
    .rxPacketData      (rxPacketData),
    .getTxPacketData   (getTxPacketData),
    .txPacketData      (txPacketData),
    .flush             (flush),
    .bufferOccupancy   (bufferOccupancy),
    .accessError       (accessError)
  );

  byte unsigned q[$];
  logic [31:0]  m_rdata = '0;
  logic         m_err   = 1'b0;
  int           n_vec   = 0;
  int           n_err   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] ds);
    case (ds)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  // Reference: a plain byte queue, with all limits judged on the size at cycle start.
  task automatic model(input logic st, input logic gr, input logic [1:0] ds,
                       input logic [31:0] wd, input logic sr, input logic [7:0] rb,
                       input logic gt, input logic fl, input logic rst_n);
    int occ;
    int n;
    bit bad;
    occ = q.size();
    n   = size_bytes(ds);
    bad = (ds == 2'b11);
    m_err = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_rdata = '0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (gr) begin
        if (bad || occ < n) begin
          m_err   = 1'b1;
          m_rdata = '0;
        end else begin
          m_rdata = '0;
          for (int k = 0; k < n; k++) m_rdata[8*k +: 8] = q.pop_front();
        end
        if (gt) m_err = 1'b1;
      end else if (gt) begin
        if (occ == 0) m_err = 1'b1;
        else void'(q.pop_front());
      end
      if (st) begin
        if (bad || (64 - occ) < n) m_err = 1'b1;
        else for (int k = 0; k < n; k++) q.push_back(wd[8*k +: 8]);
        if (sr) m_err = 1'b1;
      end else if (sr) begin
        if (occ == 64) m_err = 1'b1;
        else q.push_back(rb);
      end
    end
  endtask

  task automatic step(input logic st, input logic gr, input logic [1:0] ds,
                      input logic [31:0] wd, input logic sr, input logic [7:0] rb,
                      input logic gt, input logic fl, input logic rst_n);
    logic [7:0] head;
    storeTxData       = st;
    getRxData         = gr;
    dataSize          = ds;
    txWData           = wd;
    storeRxPacketData = sr;
    rxPacketData      = rb;
    getTxPacketData   = gt;
    flush             = fl;
    nRst              = rst_n;
    model(st, gr, ds, wd, sr, rb, gt, fl, rst_n);
    @(posedge clk);
    #1;
    head = (q.size() != 0) ? q[0] : 8'h00;
    check_eq("occupancy", 32'(bufferOccupancy), 32'(q.size()));
    check_eq("accessError", 32'(accessError), 32'(m_err));
    check_eq("rxRData", rxRData, m_rdata);
    check_eq("txPacketData", 32'(txPacketData), 32'(head));
  endtask

  task automatic idle();
    step(0, 0, 2'b00, '0, 0, 8'h00, 0, 0, 1);
  endtask

  initial begin
    logic [7:0] exp_b [4];
    nRst = 1'b0; storeTxData = 1'b0; getRxData = 1'b0; dataSize = 2'b00;
    txWData = '0; storeRxPacketData = 1'b0; rxPacketData = '0;
    getTxPacketData = 1'b0; flush = 1'b0;

    // Reset state
    step(0, 0, 2'b00, '0, 0, 8'h00, 0, 0, 0);
    step(1, 1, 2'b10, 32'h12345678, 1, 8'h11, 1, 0, 0);
    check_eq("rst_occ", 32'(bufferOccupancy), 32'd0);
    check_eq("rst_rdata", rxRData, 32'd0);
    check_eq("rst_tx", 32'(txPacketData), 32'd0);
    check_eq("rst_err", 32'(accessError), 32'd0);

    // Word write then byte pops
    step(1, 0, 2'b10, 32'hDDCCBBAA, 0, 8'h00, 0, 0, 1);
    check_eq("ww_occ", 32'(bufferOccupancy), 32'd4);
    exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
    for (int i = 0; i < 4; i++) begin
      check_eq("ww_head", 32'(txPacketData), 32'(exp_b[i]));
      step(0, 0, 2'b00, '0, 0, 8'h00, 1, 0, 1);
    end
    check_eq("ww_empty", 32'(bufferOccupancy), 32'd0);

    // RX bytes then AHB half-word and byte reads
    step(0, 0, 2'b00, '0, 1, 8'h11, 0, 0, 1);
    step(0, 0, 2'b00, '0, 1, 8'h22, 0, 0, 1);
    step(0, 0, 2'b00, '0, 1, 8'h33, 0, 0, 1);
    step(0, 1, 2'b01, '0, 0, 8'h00, 0, 0, 1);
    check_eq("rx_half", rxRData, 32'h00002211);
    idle();
    check_eq("rx_hold", rxRData, 32'h00002211);
    step(0, 1, 2'b00, '0, 0, 8'h00, 0, 0, 1);
    check_eq("rx_byte", rxRData, 32'h00000033);

    // Fill to 64, overflow, then drain to 1 and underflow a word read
    for (int i = 0; i < 16; i++) step(1, 0, 2'b10, $urandom, 0, 8'h00, 0, 0, 1);
    check_eq("full_occ", 32'(bufferOccupancy), 32'd64);
    step(1, 0, 2'b00, 32'h000000EE, 0, 8'h00, 0, 0, 1);
    check_eq("ovf_err", 32'(accessError), 32'd1);
    check_eq("ovf_occ", 32'(bufferOccupancy), 32'd64);
    step(0, 0, 2'b00, '0, 1, 8'h77, 0, 0, 1);
    check_eq("ovf_usb_err", 32'(accessError), 32'd1);
    for (int i = 0; i < 15; i++) step(0, 1, 2'b10, '0, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, '0, 0, 8'h00, 1, 0, 1);
    check_eq("one_occ", 32'(bufferOccupancy), 32'd1);
    step(0, 1, 2'b10, '0, 0, 8'h00, 0, 0, 1);
    check_eq("udf_err", 32'(accessError), 32'd1);
    check_eq("udf_rdata", rxRData, 32'd0);
    check_eq("udf_occ", 32'(bufferOccupancy), 32'd1);
    idle();
    check_eq("err_pulse", 32'(accessError), 32'd0);

    // Wrap-around: align pointers to 62, word write, pop across 63->0
    step(0, 0, 2'b00, '0, 0, 8'h00, 0, 1, 1);
    for (int i = 0; i < 62; i++) step(0, 0, 2'b00, '0, 1, 8'(i), 0, 0, 1);
    for (int i = 0; i < 62; i++) step(0, 0, 2'b00, '0, 0, 8'h00, 1, 0, 1);
    step(1, 0, 2'b10, 32'h44332211, 0, 8'h00, 0, 0, 1);
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      check_eq("wrap_head", 32'(txPacketData), 32'(exp_b[i]));
      step(0, 0, 2'b00, '0, 0, 8'h00, 1, 0, 1);
    end
    check_eq("wrap_empty", 32'(bufferOccupancy), 32'd0);
    step(0, 0, 2'b00, '0, 0, 8'h00, 1, 0, 1);
    check_eq("pop_empty_err", 32'(accessError), 32'd1);

    // Write-side contention, then flush beating a word write
    step(1, 0, 2'b00, 32'h0000005A, 1, 8'hA5, 0, 0, 1);
    check_eq("cont_err", 32'(accessError), 32'd1);
    check_eq("cont_occ", 32'(bufferOccupancy), 32'd1);
    check_eq("cont_head", 32'(txPacketData), 32'h5A);
    step(1, 0, 2'b10, 32'hCAFEF00D, 0, 8'h00, 0, 1, 1);
    check_eq("flush_occ", 32'(bufferOccupancy), 32'd0);
    check_eq("flush_err", 32'(accessError), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] ds;
      ds = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 25, ds, $urandom,
           $urandom_range(0, 99) < 35, 8'($urandom), $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 2, $urandom_range(0, 199) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_buffer.md
Name: data_buffer

Overview:
- 64-byte circular byte FIFO between the AHB slave state controller and the USB packet stages.
- AHB side: the controller's storeTxData/getRxData strobes and dataSize move 1, 2 or 4 bytes per cycle.
- USB side: the RX packet decoder pushes one byte per cycle; the TX packet encoder pops one byte per cycle.
- Reports occupancy to the controller (buffer-occupancy register, bufferReserved decisions) and flags illegal accesses.

Parameters:
- DEPTH, 64, byte capacity; must be a power of two.
- PTR_W, 7, pointer width = log2(DEPTH)+1 (extra wrap bit).

Ports:
- clk  in  1  system clock, rising edge
- nRst  in  1  reset, synchronous, active-low
- storeTxData  in  1  AHB write strobe from state controller
- getRxData  in  1  AHB read strobe from state controller
- dataSize  in  2  AHB transfer size: 00=1 byte, 01=2, 10=4, 11=illegal
- txWData  in  32  AHB write data (hwdata)
- rxRData  out  32  AHB read data, to hrdata mux
- storeRxPacketData  in  1  USB RX byte push
- rxPacketData  in  8  USB RX byte
- getTxPacketData  in  1  USB TX byte pop
- txPacketData  out  8  head byte for USB TX
- flush  in  1  clear buffer (from controller register write)
- bufferOccupancy  out  7  bytes stored, 0..64
- accessError  out  1  one-cycle pulse on a rejected operation

Behaviour:
- One clock (clk). Reset is synchronous and active-low (nRst sampled on rising clk).
- Reset: wrPtr=rdPtr=0, bufferOccupancy=0, rxRData=0, accessError=0. Memory is not reset.
- Storage: wrPtr/rdPtr are PTR_W bits. Index = ptr[5:0]; the top bit is the wrap flag.
  - occupancy = wrPtr - rdPtr (mod 128), registered as bufferOccupancy.
  - Full = 64, empty = 0.
- N = bytes for dataSize: 1, 2 or 4. dataSize=11 on any AHB strobe is rejected with accessError.
- AHB write (storeTxData):
  - Little-endian. txWData[7:0] goes to mem[wrPtr], then [15:8], and so on, up to N bytes.
  - wrPtr += N, all in one cycle.
  - If free space (64 - occupancy at cycle start) < N: nothing is written and accessError pulses.
- AHB read (getRxData):
  - N bytes are popped from the head. rxRData is registered, valid the cycle after the strobe (latency 1), and holds until the next read.
  - Byte k of the pop goes to rxRData[8k+7:8k]. Bytes at or above N are zero-filled.
  - If occupancy < N: no pop, rxRData=0, accessError pulses.
- USB push (storeRxPacketData): writes rxPacketData at wrPtr, wrPtr += 1. If full: dropped, accessError.
- USB pop (getTxPacketData):
  - txPacketData is combinational mem[rdPtr[5:0]], forced to 0 when empty (show-ahead). rdPtr += 1.
  - If empty: ignored, accessError.
- Simultaneous events:
  - flush has top priority. Both pointers go to 0 and occupancy to 0 next cycle; all other strobes that cycle are ignored; no error.
  - storeTxData with storeRxPacketData: the AHB write proceeds, the USB push is dropped, accessError.
  - getRxData with getTxPacketData: the AHB read proceeds, the USB pop is ignored, accessError.
  - One write-side plus one read-side operation in the same cycle is legal.
    - Full/empty checks use occupancy at cycle start (no bypass).
    - New occupancy = old + written - read.
    - Reading from empty while writing in the same cycle fails the read.
- Wrap-around: multi-byte accesses crossing index 63→0 split correctly. Pointers wrap mod 128.
- accessError: exactly one cycle per offending cycle, even with multiple faults. Deasserted otherwise.
- Reset mid-operation: nRst=0 overrides all strobes that cycle. State returns to reset values; the buffer reads empty afterwards.

Test Plan:
- Reset → bufferOccupancy=0, rxRData=0, txPacketData=0, accessError=0.
- Word write then pops:
  - Stimulus: storeTxData, dataSize=10, txWData=32'hDDCCBBAA.
  - Response: occupancy=4. Four getTxPacketData pops yield AA, BB, CC, DD; occupancy=0.
- RX bytes then AHB reads:
  - Stimulus: push 11,22,33 via storeRxPacketData; getRxData dataSize=01; then getRxData dataSize=00.
  - Response: rxRData=32'h00002211 next cycle, then 32'h00000033.
- Full and underflow checks:
  - Stimulus: sixteen word writes (occupancy 64); one more byte write; then with occupancy 1, a word read.
  - Response: the extra write gives an accessError pulse and occupancy stays 64. The word read gives an accessError pulse, rxRData=0, occupancy stays 1.
- Wrap-around:
  - Stimulus: bring wrPtr/rdPtr to 62 (62 byte pushes, 62 pops); word write 32'h44332211; pops.
  - Response: bytes 11,22,33,44 in order across the 63→0 boundary; occupancy ends at 0.
- Contention and flush:
  - Stimulus: storeTxData (1 byte, 8'h5A) and storeRxPacketData (8'hA5) in the same cycle; then flush together with a word write.
  - Response: only 5A stored, accessError pulses. After the flush, occupancy=0 with no accessError.
